// File: rtl/pytxscobufctrl.sv
// Transmit-side SCO/eSCO ping-pong payload buffer: the BSM fills one bank while
// the link controller reads the other; banks swap on each SCO slot pulse.
module pytxscobufctrl #(
    parameter int AW = 6
) (
    input  logic          clk_6M,
    input  logic          rstz,
    input  logic          tsco_p,
    input  logic          bsm_we,
    input  logic [31:0]   bsm_din,
    input  logic          bsm_flush,
    input  logic          lnctrl_cs,
    input  logic [AW-1:0] lnctrl_addr,
    output logic [31:0]   lnctrl_dout,
    output logic [AW:0]   tx_len,
    output logic          tx_valid,
    output logic [AW:0]   fill_cnt,
    output logic          fill_full,
    output logic          underrun_p,
    output logic          overrun_p
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [31:0] mem [0:2*DEPTH-1];

    logic          sel_reg;
    logic [AW:0]   wptr_reg;
    logic [AW:0]   tx_len_reg;
    logic          tx_valid_reg;
    logic [31:0]   dout_reg;
    logic          underrun_reg;
    logic          overrun_reg;

    logic          wr_ok;
    logic [AW:0]   len_now;
    logic          swap;
    logic          underrun;
    logic          rd_hit;

    assign fill_full = (wptr_reg == DEPTH_W);
    assign fill_cnt  = wptr_reg;

    // Flush beats a same-cycle write, so a flushed cycle never stores a word.
    assign wr_ok    = bsm_we & ~fill_full & ~bsm_flush;
    assign len_now  = wptr_reg + {{AW{1'b0}}, wr_ok};
    assign swap     = tsco_p & ~bsm_flush & (len_now != '0);
    assign underrun = tsco_p & ~swap;
    assign rd_hit   = tx_valid_reg & ({1'b0, lnctrl_addr} < tx_len_reg);

    always_ff @(posedge clk_6M) begin
        if (wr_ok)
            mem[{sel_reg, wptr_reg[AW-1:0]}] <= bsm_din;
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            sel_reg      <= 1'b0;
            wptr_reg     <= '0;
            tx_len_reg   <= '0;
            tx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            underrun_reg <= underrun;
            overrun_reg  <= bsm_we & fill_full & ~bsm_flush;
            if (swap) begin
                sel_reg      <= ~sel_reg;
                tx_len_reg   <= len_now;
                tx_valid_reg <= 1'b1;
                wptr_reg     <= '0;
            end else if (underrun) begin
                tx_len_reg   <= '0;
                tx_valid_reg <= 1'b0;
                wptr_reg     <= '0;
            end else if (bsm_flush) begin
                wptr_reg <= '0;
            end else if (wr_ok) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
        end
    end

    // Read uses the pre-swap bank select, so a swap-cycle read sees the old drain bank.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz)
            dout_reg <= '0;
        else if (lnctrl_cs)
            dout_reg <= rd_hit ? mem[{~sel_reg, lnctrl_addr}] : 32'h0;
    end

    assign lnctrl_dout = dout_reg;
    assign tx_len      = tx_len_reg;
    assign tx_valid    = tx_valid_reg;
    assign underrun_p  = underrun_reg;
    assign overrun_p   = overrun_reg;

endmodule

// File: tb/tb_pytxscobufctrl.sv
// Directed self-checking bench for the TX SCO ping-pong buffer.
module tb_pytxscobufctrl;

    localparam int AW = 6;

    logic          clk_6M = 1'b0;
    logic          rstz = 1'b1;
    logic          tsco_p = 1'b0;
    logic          bsm_we = 1'b0;
    logic [31:0]   bsm_din = '0;
    logic          bsm_flush = 1'b0;
    logic          lnctrl_cs = 1'b0;
    logic [AW-1:0] lnctrl_addr = '0;
    logic [31:0]   lnctrl_dout;
    logic [AW:0]   tx_len;
    logic          tx_valid;
    logic [AW:0]   fill_cnt;
    logic          fill_full;
    logic          underrun_p;
    logic          overrun_p;

    int checks = 0;
    int errors = 0;

    pytxscobufctrl #(.AW(AW)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .tsco_p(tsco_p), .bsm_we(bsm_we),
        .bsm_din(bsm_din), .bsm_flush(bsm_flush), .lnctrl_cs(lnctrl_cs),
        .lnctrl_addr(lnctrl_addr), .lnctrl_dout(lnctrl_dout), .tx_len(tx_len),
        .tx_valid(tx_valid), .fill_cnt(fill_cnt), .fill_full(fill_full),
        .underrun_p(underrun_p), .overrun_p(overrun_p)
    );

    always #5 clk_6M = ~clk_6M;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_6M);
        rstz = 1'b0;
        #1;
        rstz = 1'b1;
        tick();
    endtask

    task automatic push(input logic [31:0] w);
        bsm_we = 1'b1;
        bsm_din = w;
        tick();
        bsm_we = 1'b0;
    endtask

    task automatic slot();
        tsco_p = 1'b1;
        tick();
        tsco_p = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [31:0] exp);
        lnctrl_cs = 1'b1;
        lnctrl_addr = AW'(a);
        tick();
        lnctrl_cs = 1'b0;
        chk(tag, lnctrl_dout, exp);
    endtask

    initial begin
        // Reset state
        @(negedge clk_6M);
        rstz = 1'b0;
        #1;
        chk("rst_tx_len", 32'(tx_len), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_fill_cnt", 32'(fill_cnt), 0);
        chk("rst_fill_full", 32'(fill_full), 0);
        chk("rst_dout", lnctrl_dout, 0);
        chk("rst_underrun", 32'(underrun_p), 0);
        chk("rst_overrun", 32'(overrun_p), 0);
        rstz = 1'b1;
        tick();

        // 2: tsco_p straight after reset is an underrun
        slot();
        chk("t2_underrun", 32'(underrun_p), 1);
        chk("t2_tx_valid", 32'(tx_valid), 0);
        tick();
        chk("t2_underrun_clr", 32'(underrun_p), 0);
        rd("t2_rd0", 0, 0);

        // 1: eight words, swap, read back
        do_reset();
        for (int i = 0; i < 8; i++) push(32'h100 + 32'(i));
        chk("t1_fill_cnt_pre", 32'(fill_cnt), 8);
        slot();
        chk("t1_tx_len", 32'(tx_len), 8);
        chk("t1_tx_valid", 32'(tx_valid), 1);
        chk("t1_fill_cnt", 32'(fill_cnt), 0);
        chk("t1_no_underrun", 32'(underrun_p), 0);
        for (int i = 0; i < 8; i++) rd($sformatf("t1_rd%0d", i), i, 32'h100 + 32'(i));
        // empty slot after a valid one: underrun and reads go to zero
        slot();
        chk("t2b_underrun", 32'(underrun_p), 1);
        chk("t2b_tx_valid", 32'(tx_valid), 0);
        chk("t2b_tx_len", 32'(tx_len), 0);
        rd("t2b_rd0", 0, 0);

        // 3: fill to DEPTH, overrun on the 65th
        do_reset();
        for (int i = 0; i < 64; i++) push(32'h2000 + 32'(i));
        chk("t3_fill_full", 32'(fill_full), 1);
        chk("t3_fill_cnt", 32'(fill_cnt), 64);
        chk("t3_no_overrun", 32'(overrun_p), 0);
        push(32'hDEAD);
        chk("t3_overrun", 32'(overrun_p), 1);
        chk("t3_fill_cnt_sat", 32'(fill_cnt), 64);
        tick();
        chk("t3_overrun_clr", 32'(overrun_p), 0);
        slot();
        chk("t3_tx_len", 32'(tx_len), 64);
        chk("t3_fill_full_clr", 32'(fill_full), 0);
        rd("t3_rd0", 0, 32'h2000);
        rd("t3_rd63", 63, 32'h203F);

        // 4: write coincident with tsco_p joins the outgoing bank
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(i));
        bsm_we = 1'b1;
        bsm_din = 32'hABCD;
        tsco_p = 1'b1;
        tick();
        bsm_we = 1'b0;
        tsco_p = 1'b0;
        chk("t4_tx_len", 32'(tx_len), 4);
        chk("t4_fill_cnt", 32'(fill_cnt), 0);
        chk("t4_tx_valid", 32'(tx_valid), 1);
        rd("t4_rd3", 3, 32'hABCD);
        rd("t4_rd0", 0, 32'h300);

        // 5: continuous ping-pong, reading drain while filling
        do_reset();
        for (int i = 0; i < 6; i++) push(32'h5000 + 32'(i));
        slot();
        for (int k = 1; k < 5; k++) begin
            for (int i = 0; i < 6; i++) begin
                bsm_we = 1'b1;
                bsm_din = 32'h5000 + 32'(k * 16 + i);
                lnctrl_cs = 1'b1;
                lnctrl_addr = AW'(i);
                tick();
                chk($sformatf("t5_s%0d_rd%0d", k - 1, i), lnctrl_dout,
                    32'h5000 + 32'((k - 1) * 16 + i));
            end
            bsm_we = 1'b0;
            lnctrl_cs = 1'b0;
            slot();
            chk($sformatf("t5_s%0d_len", k), 32'(tx_len), 6);
        end
        for (int i = 0; i < 6; i++)
            rd($sformatf("t5_s4_rd%0d", i), i, 32'h5000 + 32'(64 + i));

        // 6: flush then tsco_p is an underrun; out-of-range read is zero
        do_reset();
        for (int i = 0; i < 5; i++) push(32'h600 + 32'(i));
        bsm_flush = 1'b1;
        tick();
        bsm_flush = 1'b0;
        chk("t6_fill_cnt", 32'(fill_cnt), 0);
        slot();
        chk("t6_underrun", 32'(underrun_p), 1);
        chk("t6_tx_valid", 32'(tx_valid), 0);
        push(32'h610);
        push(32'h611);
        slot();
        chk("t6_tx_len", 32'(tx_len), 2);
        rd("t6_rd1", 1, 32'h611);
        rd("t6_rd2_oob", 2, 0);
        rd("t6_rd63_oob", 63, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
